// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, exception codes,
// writeback source select and the access FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_TMO   = 2'b10;
  localparam logic [1:0] EXC_ILL   = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_LD  = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension. Full-width loads pass
// through untouched regardless of load_unsigned.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OW = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OW-1:0]     addr_lo,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              sign;

  // Shift the addressed lane down, then fill above the access width.
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_B:    begin mask = DATA_W'(8'hFF);         sign = sh[7];        end
      SZ_H:    begin mask = DATA_W'(16'hFFFF);      sign = sh[15];       end
      SZ_W:    begin mask = DATA_W'(32'hFFFFFFFF);  sign = sh[31];       end
      default: begin mask = '1;                     sign = sh[DATA_W-1]; end
    endcase
    data = (sh & mask) | ((sign && !load_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues sized loads/stores over a req/ack port with
// a bus timeout, aligns load data and registers the MEM/WB bundle.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [REG_AW-1:0] write_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic              reg_write,
  input  logic [1:0]        mem_to_reg,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              lu_op,
  input  logic [DATA_W-1:0] lu_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] mem_wb_data,
  output logic [REG_AW-1:0] mem_wb_reg,
  output logic              mem_wb_regwrite,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [DATA_W-1:0] exc_addr
);

  localparam int NB = DATA_W/8;
  localparam int OW = $clog2(NB);

  state_t            state, state_nx;
  logic [15:0]       cnt;
  logic [16:0]       cnt_inc;
  logic [DATA_W-1:0] l_addr, l_wdata;
  logic [1:0]        l_size;
  logic              l_we, l_uns;

  logic [DATA_W-1:0] cur_addr, cur_wdata;
  logic [1:0]        cur_size;
  logic              cur_we, cur_uns;

  logic              access, illegal, misal, fault, tmo;
  logic              req, stl;
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] wrep, ld_data, wb_sel;

  // In WAIT the request is driven from the copies latched at issue.
  assign cur_addr  = (state == S_WAIT) ? l_addr  : alu_s;
  assign cur_wdata = (state == S_WAIT) ? l_wdata : mem_write_data;
  assign cur_size  = (state == S_WAIT) ? l_size  : size;
  assign cur_we    = (state == S_WAIT) ? l_we    : mem_write;
  assign cur_uns   = (state == S_WAIT) ? l_uns   : load_unsigned;

  assign access  = (state == S_IDLE) && (mem_read || mem_write);
  assign illegal = (size == SZ_D) && (DATA_W == 32);
  assign misal   = |(alu_s[2:0] & align_mask(size));
  assign fault   = access && (illegal || misal);
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  // An ack in the timeout cycle wins, so the abort requires no ack.
  assign tmo     = (state == S_WAIT) && !mem_ack && (cnt_inc == 17'(TIMEOUT));

  // Next-state and request/stall decode.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    stl      = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !fault) begin
          req = 1'b1;
          if (!mem_ack) begin
            stl      = 1'b1;
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (mem_ack || tmo) state_nx = S_IDLE;
        else                stl      = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte-enable base pattern and lane replication of store data.
  always_comb begin
    case (cur_size)
      SZ_B:    begin be_base = NB'(1);  wrep = {NB{cur_wdata[7:0]}};          end
      SZ_H:    begin be_base = NB'(3);  wrep = {(NB/2){cur_wdata[15:0]}};     end
      SZ_W:    begin be_base = NB'(15); wrep = {(DATA_W/32){cur_wdata[31:0]}}; end
      default: begin be_base = '1;      wrep = cur_wdata;                     end
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign mem_req   = reset_b && req;
  assign stall     = reset_b && stl;
  assign mem_we    = mem_req && cur_we;
  assign mem_addr  = mem_req ? {cur_addr[DATA_W-1:OW], {OW{1'b0}}} : '0;
  assign mem_be    = mem_req ? (be_base << cur_addr[OW-1:0]) : '0;
  assign mem_wdata = mem_req ? wrep : '0;

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata         (mem_rdata),
    .addr_lo       (cur_addr[OW-1:0]),
    .size          (cur_size),
    .load_unsigned (cur_uns),
    .data          (ld_data)
  );

  assign wb_sel = lu_op         ? lu_data  :
                  mem_to_reg[1] ? pc_plus4 :
                  mem_to_reg[0] ? ld_data  : alu_s;

  // FSM state, timeout counter and request latches.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= S_IDLE;
      cnt     <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_size  <= '0;
      l_we    <= 1'b0;
      l_uns   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        cnt     <= '0;
        l_addr  <= alu_s;
        l_wdata <= mem_write_data;
        l_size  <= size;
        l_we    <= mem_write;
        l_uns   <= load_unsigned;
      end else begin
        cnt <= cnt_inc[15:0];
      end
    end
  end

  // MEM/WB register: bubble while stalled, suppressed write on faults.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mem_wb_data     <= '0;
      mem_wb_reg      <= '0;
      mem_wb_regwrite <= 1'b0;
    end else if (stl) begin
      mem_wb_regwrite <= 1'b0;
    end else begin
      mem_wb_data     <= wb_sel;
      mem_wb_reg      <= write_reg;
      mem_wb_regwrite <= reg_write && !fault && !tmo;
    end
  end

  // Exception pulse; code and address hold until the next fault.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      exc_addr  <= '0;
    end else begin
      exc_valid <= fault || tmo;
      if (fault || tmo) begin
        exc_code <= tmo ? EXC_TMO : (illegal ? EXC_ILL : EXC_MISAL);
        exc_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (DATA_W=32, TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [31:0] alu_s, mem_write_data, pc_plus4, lu_data, mem_rdata;
  logic [4:0]  write_reg;
  logic        mem_read, mem_write, load_unsigned, reg_write, lu_op, mem_ack;
  logic [1:0]  size, mem_to_reg;
  logic        mem_req, mem_we, stall, mem_wb_regwrite, exc_valid;
  logic [31:0] mem_addr, mem_wdata, mem_wb_data, exc_addr;
  logic [3:0]  mem_be;
  logic [4:0]  mem_wb_reg;
  logic [1:0]  exc_code;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset_b(reset_b), .alu_s(alu_s), .mem_write_data(mem_write_data),
    .write_reg(write_reg), .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_plus4(pc_plus4), .lu_op(lu_op), .lu_data(lu_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .mem_wb_data(mem_wb_data),
    .mem_wb_reg(mem_wb_reg), .mem_wb_regwrite(mem_wb_regwrite), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_s = '0; mem_write_data = '0; write_reg = '0; mem_read = 0; mem_write = 0;
    size = 2'b00; load_unsigned = 0; reg_write = 0; mem_to_reg = 2'b00;
    pc_plus4 = '0; lu_op = 0; lu_data = '0; mem_rdata = '0; mem_ack = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                      input logic [31:0] rd, input logic ack);
    idle_in();
    alu_s = a; size = sz; load_unsigned = uns; mem_read = 1; reg_write = 1;
    mem_to_reg = 2'b01; write_reg = 5'd7; mem_rdata = rd; mem_ack = ack;
  endtask

  initial begin
    idle_in();
    reset_b = 0;
    #2;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wbdata", mem_wb_data, 32'd0);
    chk("rst_wbrw", {31'b0, mem_wb_regwrite}, 32'd0);
    chk("rst_exc", {31'b0, exc_valid}, 32'd0);
    tick(); tick();
    reset_b = 1;
    tick();

    // Zero-wait word load
    load(32'h100, 2'b10, 0, 32'hDEADBEEF, 1);
    #3;
    chk("zw_req", {31'b0, mem_req}, 32'd1);
    chk("zw_stall", {31'b0, stall}, 32'd0);
    chk("zw_addr", mem_addr, 32'h100);
    chk("zw_be", {28'b0, mem_be}, 32'hF);
    tick(); idle_in();
    chk("zw_data", mem_wb_data, 32'hDEADBEEF);
    chk("zw_rw", {31'b0, mem_wb_regwrite}, 32'd1);
    chk("zw_reg", {27'b0, mem_wb_reg}, 32'd7);

    // Signed byte load, ack 3 cycles after request
    load(32'h103, 2'b00, 0, 32'h80000000, 0);
    #3;
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    for (int c = 0; c < 3; c++) begin
      chk("sb_stall", {31'b0, stall}, 32'd1);
      tick();
      #3;
    end
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_bubble", {31'b0, mem_wb_regwrite}, 32'd0);
    mem_ack = 1;
    #1;
    chk("sb_stall_drop", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    chk("sb_data", mem_wb_data, 32'hFFFFFF80);
    chk("sb_rw", {31'b0, mem_wb_regwrite}, 32'd1);

    // Unsigned byte load, same shape
    load(32'h103, 2'b00, 1, 32'h80000000, 0);
    tick(); tick(); tick();
    mem_ack = 1;
    #1;
    chk("ub_stall", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    chk("ub_data", mem_wb_data, 32'h00000080);

    // Half store
    idle_in();
    alu_s = 32'h202; mem_write = 1; size = 2'b01; mem_write_data = 32'h1234ABCD; mem_ack = 1;
    #3;
    chk("hs_be", {28'b0, mem_be}, 32'hC);
    chk("hs_wdata", mem_wdata, 32'hABCDABCD);
    chk("hs_we", {31'b0, mem_we}, 32'd1);
    chk("hs_addr", mem_addr, 32'h200);
    tick(); idle_in();
    chk("hs_rw", {31'b0, mem_wb_regwrite}, 32'd0);

    // Misaligned word load
    load(32'h101, 2'b10, 0, 32'h0, 1);
    #3;
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    chk("mis_exc", {31'b0, exc_valid}, 32'd1);
    chk("mis_code", {30'b0, exc_code}, 32'd1);
    chk("mis_addr", exc_addr, 32'h101);
    chk("mis_rw", {31'b0, mem_wb_regwrite}, 32'd0);
    tick();
    chk("mis_pulse", {31'b0, exc_valid}, 32'd0);

    // Illegal doubleword on a 32-bit stage
    load(32'h108, 2'b11, 0, 32'h0, 1);
    #3;
    chk("ill_req", {31'b0, mem_req}, 32'd0);
    tick(); idle_in();
    chk("ill_code", {30'b0, exc_code}, 32'd3);
    chk("ill_exc", {31'b0, exc_valid}, 32'd1);

    // Timeout: no ack at all
    load(32'h300, 2'b10, 0, 32'h0, 0);
    #3;
    for (int c = 0; c < 4; c++) begin
      chk("to_stall", {31'b0, stall}, 32'd1);
      tick();
      #3;
    end
    chk("to_stall_drop", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    #1;
    chk("to_exc", {31'b0, exc_valid}, 32'd1);
    chk("to_code", {30'b0, exc_code}, 32'd2);
    chk("to_addr", exc_addr, 32'h300);
    chk("to_rw", {31'b0, mem_wb_regwrite}, 32'd0);
    chk("to_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("to_pulse", {31'b0, exc_valid}, 32'd0);

    // Ack in the timeout cycle wins
    load(32'h304, 2'b10, 0, 32'hCAFEF00D, 0);
    tick(); tick(); tick(); tick();
    mem_ack = 1;
    #1;
    chk("tw_stall", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    chk("tw_exc", {31'b0, exc_valid}, 32'd0);
    chk("tw_data", mem_wb_data, 32'hCAFEF00D);
    chk("tw_rw", {31'b0, mem_wb_regwrite}, 32'd1);

    // Writeback selects: upper immediate, then link value
    idle_in();
    reg_write = 1; write_reg = 5'd3; lu_op = 1; lu_data = 32'hABC00000; alu_s = 32'h55;
    mem_to_reg = 2'b10; pc_plus4 = 32'h44;
    tick();
    chk("lu_data", mem_wb_data, 32'hABC00000);
    lu_op = 0;
    tick();
    chk("pc_data", mem_wb_data, 32'h44);
    mem_to_reg = 2'b00;
    tick(); idle_in();
    chk("alu_data", mem_wb_data, 32'h55);

    // Reset asserted mid-WAIT, then recovery
    load(32'h400, 2'b10, 0, 32'h0, 0);
    tick(); tick();
    chk("rw_req_pre", {31'b0, mem_req}, 32'd1);
    reset_b = 0;
    #1;
    chk("rw_req", {31'b0, mem_req}, 32'd0);
    chk("rw_stall", {31'b0, stall}, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    chk("rw_wbdata", mem_wb_data, 32'd0);
    chk("rw_exc", {31'b0, exc_valid}, 32'd0);
    idle_in();
    tick(); tick();
    reset_b = 1;
    tick();
    chk("rw_noexc", {31'b0, exc_valid}, 32'd0);
    load(32'h104, 2'b10, 0, 32'h13579BDF, 1);
    #3;
    chk("rc_stall", {31'b0, stall}, 32'd0);
    tick(); idle_in();
    chk("rc_data", mem_wb_data, 32'h13579BDF);
    chk("rc_rw", {31'b0, mem_wb_regwrite}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage that replaces the fixed word-only, single-cycle MEM stage. Issues byte/half/word (and doubleword when `DATA_W=64`) loads and stores over a request/acknowledge memory port with variable latency and a bus timeout. Aligns and extends load data, flags misaligned or timed-out accesses, and registers the writeback bundle into the MEM/WB register. Sits between EX/MEM and the register-file writeback, and drives a pipeline stall while an access is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: data and address width; legal values are 32 and 64.
- `REG_AW`, 5: register-index width.
- `TIMEOUT`, 255: cycles without `mem_ack` before the access is aborted; 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: stage clock.
- `reset_b` in 1: asynchronous active-low reset.
- `alu_s` in DATA_W: address for loads/stores; ALU result otherwise.
- `mem_write_data` in DATA_W: store data, right-justified.
- `write_reg` in REG_AW: destination register.
- `mem_read`, `mem_write` in 1: access type; never both high.
- `size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `load_unsigned` in 1: 1 zero-extends loads, 0 sign-extends.
- `reg_write` in 1: instruction writes the register file.
- `mem_to_reg` in 2: 00 ALU, 01 load data, 1x `pc_plus4`.
- `pc_plus4` in DATA_W: link value.
- `lu_op` in 1: select `lu_data`; takes priority over `mem_to_reg`.
- `lu_data` in DATA_W: upper-immediate value.
- `mem_req` out 1: access request.
- `mem_we` out 1: write enable.
- `mem_addr` out DATA_W: `alu_s` with the low log2(DATA_W/8) bits cleared.
- `mem_be` out DATA_W/8: byte enables.
- `mem_wdata` out DATA_W: store data replicated into lanes.
- `mem_rdata` in DATA_W: read data; valid when `mem_ack` is high.
- `mem_ack` in 1: access complete.
- `stall` out 1: freezes IF..EX/MEM.
- `mem_wb_data` out DATA_W: registered writeback data.
- `mem_wb_reg` out REG_AW: registered destination.
- `mem_wb_regwrite` out 1: registered write enable.
- `exc_valid` out 1: one-cycle registered exception pulse.
- `exc_code` out 2: 01 misaligned, 10 bus timeout, 11 illegal size.
- `exc_addr` out DATA_W: faulting `alu_s`.

## Operation
- FSM states: IDLE and WAIT.
- **IDLE, no access:** the writeback bundle is loaded on the clock edge; `stall` is 0.
- **IDLE, access:**
  - Legality check first.
  - Size 11 with `DATA_W=32` is illegal (code 11).
  - Half with `a[0]`≠0, word with `a[1:0]`≠0, or double with `a[2:0]`≠0 is misaligned (code 01).
  - A faulting access does not request. It loads the bundle with `mem_wb_regwrite`=0 and pulses `exc_valid`/`exc_code`/`exc_addr`.
- **IDLE, legal access:**
  - `mem_req`=1 combinationally, with `mem_we`=`mem_write`.
  - `mem_be`: bit mask for size at lane `alu_s` low bits; all bytes for full width.
  - `mem_wdata`: byte/half/word replicated across lanes.
  - If `mem_ack` is high in the same cycle, the access completes and the stage stays in IDLE. Otherwise `stall`=1 and the FSM goes to WAIT, with timeout counter cleared.
- **WAIT:**
  - `mem_req` stays high; all request outputs are held stable from latched copies.
  - `stall`=1; upstream inputs are also held by the stall.
  - Counter increments each cycle.
  - `mem_ack` completes the access: the bundle is loaded, `stall` drops combinationally in that cycle, and the FSM returns to IDLE.
  - When the counter reaches TIMEOUT: the FSM returns to IDLE, `mem_req` drops, `exc_valid` is pulsed with code 10, and `mem_wb_regwrite` is forced 0.
- **While stall=1:** the MEM/WB register loads a bubble (`mem_wb_regwrite`=0, data and reg held).
- **Load data path:**
  - Select the lane by `alu_s` low bits.
  - Extend per `load_unsigned`.
  - Full-width loads ignore `load_unsigned`.
- **Writeback select:** `lu_op` ? `lu_data` : `mem_to_reg` 00 ALU / 01 load / 1x `pc_plus4`.
- A store with `reg_write`=1 still writes back per `mem_to_reg`.

## Timing
- **Reset values:** all outputs and MEM/WB fields 0; FSM in IDLE; counter 0. Reset asserted during WAIT aborts the access, drops `mem_req` immediately, and raises no exception.
- **Latency:**
  - Zero-wait ack: writeback is visible 1 cycle after the request cycle.
  - N-cycle ack: `stall` is high for N cycles.
- **Timeout fires:** exactly TIMEOUT cycles after entering WAIT. An ack in the same cycle as the timeout wins, and no exception is raised.
- `mem_ack` while `mem_req`=0 is ignored.
- `exc_valid` is high for exactly one cycle per fault.

## Structure
- Shared package `mem_pkg`:
  - `size` encodings.
  - `exc_code` values.
  - `mem_to_reg` encodings.
  - FSM state enum.
- Sub-module `load_align`: combinational lane select and sign/zero extension. Parameterised by `DATA_W`; reused by the future cache.

## Test plan
- **Zero-wait word load:** `alu_s`=0x100, `mem_rdata`=0xDEADBEEF, ack the same cycle -> next cycle `mem_wb_data`=0xDEADBEEF, `mem_wb_regwrite`=1, `stall` never 1.
- **Signed byte load, 3-cycle ack:** `alu_s`=0x103, rdata=0x80000000, `load_unsigned`=0 -> `stall` high 3 cycles, then data=0xFFFFFF80. Repeat with `load_unsigned`=1 -> 0x00000080.
- **Half store:** `alu_s`=0x202, wdata=0x1234ABCD -> `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1.
- **Misaligned word:** `alu_s`=0x101 -> no `mem_req`; `exc_valid` 1 cycle, code 01, `exc_addr`=0x101, `mem_wb_regwrite`=0.
- **Timeout:** `TIMEOUT`=4, no ack -> `stall` high 4 cycles, `exc_code`=10, `mem_req` low afterwards. Ack on cycle 4 instead -> normal completion, no exception.
- **Reset mid-WAIT, then recovery:** `reset_b` low during WAIT -> all outputs 0 asynchronously. After release, a zero-wait load completes normally.
